// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter in front of one shared memory port
// Data has priority; a saturating starve counter guarantees fetch a slot after STARVE_MAX data wins.
module mem_arbiter #(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        gnt_d
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] LAT_M1     = 4'(LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_starve;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_gnt_d;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic w_any_req;
    logic w_pick_d;
    logic w_last_busy;

    assign w_any_req   = i_req | d_req;
    // Data wins every contested slot except once the fetch side has been passed over STARVE_MAX times.
    assign w_pick_d    = d_req & ~(i_req & (r_starve == STARVE_LIM));
    assign w_last_busy = (r_state == ST_BUSY) && (r_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_starve  <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_we      <= 1'b0;
            r_gnt_d   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_d <= w_pick_d;
                        r_addr  <= w_pick_d ? d_addr : i_addr;
                        r_we    <= w_pick_d & d_we;
                        r_wdata <= d_wdata;
                        r_cnt   <= LAT_M1;
                        r_state <= ST_BUSY;
                        if (!w_pick_d) begin
                            r_starve <= 4'd0;
                        end else if (i_req && (r_starve != STARVE_LIM)) begin
                            r_starve <= r_starve + 4'd1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data is captured on the final BUSY edge so it is already stable when ack is shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else if (w_last_busy && !r_we) begin
            if (r_gnt_d) begin
                r_d_rdata <= mem_rdata;
            end else begin
                r_i_rdata <= mem_rdata;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign gnt_d     = r_gnt_d;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_read  = (r_state == ST_BUSY) && !r_we;
    assign mem_write = w_last_busy && r_we;
    assign i_ack     = (r_state == ST_DONE) && !r_gnt_d;
    assign d_ack     = (r_state == ST_DONE) && r_gnt_d;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter plus directed reset and LAT=1 checks
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int SM  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_read, mem_write, busy, gnt_d;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        i_req1;
    logic [31:0] i_addr1;
    logic        d_req1, d_we1;
    logic [31:0] d_addr1, d_wdata1;
    logic        i_ack1, d_ack1, mem_read1, mem_write1, busy1, gnt_d1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    logic [31:0] tmem [64];
    logic [31:0] mmem [64];
    logic        load;

    assign mem_rdata  = tmem[mem_addr[5:0]];
    assign mem_rdata1 = mem_addr1 ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) tmem[i] <= mmem[i];
        end else if (mem_write) begin
            tmem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    mem_arbiter #(.LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy), .gnt_d(gnt_d)
    );

    mem_arbiter #(.LAT(1), .STARVE_MAX(SM)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_read(mem_read1),
        .mem_write(mem_write1), .mem_rdata(mem_rdata1), .busy(busy1), .gnt_d(gnt_d1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          arb;
    } exp_t;

    exp_t        q[$];
    int          cycle;
    bit          mon_en;
    logic [31:0] last_i, last_d;

    // Monitor: derives every expected port value from the transaction at the head of the scoreboard.
    exp_t f;
    bit   has, e_busy, e_rd, e_wr, e_ack;
    initial begin
        last_i = 32'd0;
        last_d = 32'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                has = (q.size() > 0);
                if (has) f = q[0];
                if (has && cycle > f.arb + LAT + 1) begin
                    chk("ack_timeout", 32'(cycle), 32'(f.arb + LAT + 1));
                    void'(q.pop_front());
                end else begin
                    e_busy = has && cycle >= f.arb + 1 && cycle <= f.arb + LAT + 1;
                    e_rd   = has && !f.we && cycle >= f.arb + 1 && cycle <= f.arb + LAT;
                    e_wr   = has && f.we && cycle == f.arb + LAT;
                    e_ack  = has && cycle == f.arb + LAT + 1;
                    chk("busy", busy, e_busy);
                    chk("mem_read", mem_read, e_rd);
                    chk("mem_write", mem_write, e_wr);
                    chk("two_acks", i_ack & d_ack, 0);
                    chk("i_ack", i_ack, e_ack && !f.is_d);
                    chk("d_ack", d_ack, e_ack && f.is_d);
                    if (e_busy) begin
                        chk("mem_addr", mem_addr, f.addr);
                        chk("gnt_d", gnt_d, f.is_d);
                    end
                    if (e_wr) chk("mem_wdata", mem_wdata, f.wdata);
                    if (e_ack) begin
                        if (f.we) chk("write_mem", tmem[f.addr[5:0]], f.wdata);
                        else if (f.is_d) last_d = f.rdata;
                        else last_i = f.rdata;
                        void'(q.pop_front());
                    end
                    chk("i_rdata", i_rdata, last_i);
                    chk("d_rdata", d_rdata, last_d);
                end
            end
        end
    end

    bit          i_pend, d_pend, i_gr, d_gr, got_i, got_d, pick_d, dwe_r;
    logic [31:0] ia_r, da_r, dw_r, old_val;
    int          next_arb, starve, prob;
    exp_t        e;

    initial begin
        rst = 1'b0; load = 1'b1; mon_en = 1'b0; cycle = 0;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
        for (int i = 0; i < 64; i++) mmem[i] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        load = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_gnt_d", gnt_d, 0);
        chk("rst_acks", {i_ack, d_ack, mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        chk("rst_busy1", busy1, 0);

        @(posedge clk); #1;
        rst = 1'b1; cycle = 0; mon_en = 1'b1;
        next_arb = 0; starve = 0;
        i_pend = 0; d_pend = 0; i_gr = 0; d_gr = 0;
        for (int k = 0; k < 700; k++) begin
            prob = (k < 100) ? 100 : 55;
            if (!i_pend && $urandom_range(0, 99) < prob) begin
                i_pend = 1; ia_r = 32'($urandom_range(0, 63));
            end
            if (!d_pend && $urandom_range(0, 99) < prob) begin
                d_pend = 1; da_r = 32'($urandom_range(0, 63));
                dw_r = $urandom; dwe_r = 1'($urandom_range(0, 1));
            end
            i_req   = i_pend;
            d_req   = d_pend;
            // A granted requester's payload is scrambled until ack: the latched copy must be used.
            i_addr  = i_gr ? $urandom : ia_r;
            d_addr  = d_gr ? $urandom : da_r;
            d_wdata = d_gr ? $urandom : dw_r;
            d_we    = d_gr ? 1'($urandom_range(0, 1)) : dwe_r;
            if (cycle >= next_arb && (i_pend || d_pend)) begin
                pick_d = d_pend && !(i_pend && starve == SM);
                if (!pick_d) starve = 0;
                else if (i_pend) starve = (starve < SM) ? starve + 1 : SM;
                e.is_d  = pick_d;
                e.arb   = cycle;
                e.addr  = pick_d ? da_r : ia_r;
                e.we    = pick_d && dwe_r;
                e.wdata = dw_r;
                e.rdata = mmem[e.addr[5:0]];
                if (e.we) mmem[e.addr[5:0]] = dw_r;
                q.push_back(e);
                next_arb = cycle + LAT + 2;
                if (pick_d) d_gr = 1; else i_gr = 1;
            end
            @(negedge clk);
            got_i = i_ack; got_d = d_ack;
            @(posedge clk); #1;
            cycle++;
            if (got_i) begin i_pend = 0; i_gr = 0; end
            if (got_d) begin d_pend = 0; d_gr = 0; end
        end
        i_req = 0; d_req = 0;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            @(posedge clk); #1; cycle++;
        end
        chk("drain", 32'(q.size()), 0);
        @(posedge clk); #1; cycle++;
        @(posedge clk); #1; cycle++;
        mon_en = 1'b0;

        // Directed: payload change in BUSY, then reset in the final BUSY cycle of a write.
        old_val = tmem[16];
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        d_addr = 32'h20; d_wdata = 32'h0;
        chk("dir_addr_c1", mem_addr, 32'h10);
        chk("dir_wr_c1", mem_write, 0);
        @(posedge clk); #1;
        chk("dir_wr_c2", mem_write, 1);
        chk("dir_addr_c2", mem_addr, 32'h10);
        chk("dir_wdata_c2", mem_wdata, 32'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        chk("abort_wr", mem_write, 0);
        chk("abort_busy", busy, 0);
        chk("abort_acks", {i_ack, d_ack, mem_read, gnt_d}, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_wdata", mem_wdata, 0);
        chk("abort_rdata", i_rdata | d_rdata, 0);
        d_req = 0; d_we = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_ack", d_ack, 0);
        end
        chk("abort_mem", tmem[16], old_val);

        // Arbitration resumes with the first edge after reset release.
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1; i_addr = 32'd5;
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            chk("restart_i_ack", i_ack, k == LAT + 1);
            if (k == LAT + 1) chk("restart_rdata", i_rdata, mmem[5]);
            @(posedge clk); #1;
        end
        i_req = 0;

        // LAT=1 instance: single fetch.
        i_req1 = 1; i_addr1 = 32'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat1_busy", busy1, k == 1 || k == 2);
            chk("lat1_ack", i_ack1, k == 2);
            chk("lat1_read", mem_read1, k == 1);
            if (k == 2) chk("lat1_rdata", i_rdata1, 32'h4 ^ 32'hA5A5_0000);
            @(posedge clk); #1;
            if (k == 2) i_req1 = 0;
        end
        chk("lat1_rdata_hold", i_rdata1, 32'h4 ^ 32'hA5A5_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
